xor_checksum_unit: RTL
======================

# xor_checksum_unit

Streaming, parametrised XOR checksum engine built on the team's XOR gate primitive. It accepts a frame of WIDTH-bit words over a valid/ready handshake and XOR-accumulates them into a running checksum. At end of frame it presents the checksum, its 1-bit parity, the word count and an overflow flag on a held output handshake. It sits between the memory/data path and any consumer needing cheap integrity checks, for example ROM image or RAM block verification.

## Interface
- WIDTH, 16: data word width in bits; matches the Hack word size by default.
- MAX_LEN, 256: maximum counted words per frame; must be ≥ 1.
- LEN_W, $clog2(MAX_LEN+1): width of the word counter; derived, not overridden.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data/in_last are valid this cycle.
- in_ready  output  1  unit accepts a word this cycle.
- in_data  input  WIDTH  word to fold into the checksum.
- in_last  input  1  marks the final word of the frame; qualified by in_valid.
- out_valid  output  1  result fields are valid and held.
- out_ready  input  1  consumer takes the result this cycle.
- out_sum  output  WIDTH  XOR of all accepted words in the frame.
- out_parity  output  1  XOR-reduction of out_sum.
- out_count  output  LEN_W  words accepted in the frame, saturating at MAX_LEN.
- out_overflow  output  1  frame contained more than MAX_LEN words.

## Operation
- Two states:
  - ACCUM: in_ready=1, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- in_ready and out_valid decode directly from the state register.
- An input beat is accepted when in_valid & in_ready. In ACCUM on an accepted beat:
  - acc ← acc ^ in_data.
  - If count < MAX_LEN, count ← count+1. Otherwise count holds and ovf ← 1 (sticky for the frame).
  - If in_last=1, state → DONE.
- A word beyond MAX_LEN is still XORed into acc; only the counter saturates.
- In DONE:
  - acc, count and ovf hold.
  - in_valid is ignored; no beat is accepted.
  - On out_valid & out_ready: state → ACCUM and acc, count, ovf clear to 0 on the same edge.
- out_sum=acc, out_count=count, out_overflow=ovf, out_parity=^acc. All are direct register views, so outputs are stable throughout DONE.
- Zero-length frames do not exist; every frame has at least the in_last word.
- Reset at any time, including mid-frame or in DONE, discards the frame:
  - state=ACCUM, acc=0, count=0, ovf=0.
  - Outputs at reset: in_ready=1, out_valid=0, out_sum=0, out_parity=0, out_count=0, out_overflow=0.

## Timing
- Accept rate is one word per cycle in ACCUM; idle cycles (in_valid=0) leave all state unchanged.
- Latency: out_valid rises on the first edge after the in_last beat is accepted. out_sum on that cycle already includes the last word.
- Backpressure: out_valid stays high and fields stay constant for as many cycles as out_ready is low.
- After the output handshake edge, in_ready=1 in the very next cycle. Minimum frame-to-frame turnaround is therefore 1 cycle in DONE.
- out_ready while out_valid=0 has no effect.
- Reset is asynchronous: outputs reach reset values without waiting for a clock edge. Deassertion takes effect from the next rising edge.

## Test plan
- Single-word frame: after reset, drive 0xA5A5 with in_last=1.
  - Next cycle: out_valid=1, out_sum=0xA5A5, out_parity=0, out_count=1, out_overflow=0.
- Multi-word frame with gaps: drive 0x0001, idle 2 cycles, then 0x0002, then 0x0004 with last.
  - Result: out_sum=0x0007, out_parity=1, out_count=3.
  - in_ready must be high on every ACCUM cycle.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid with 0xFFFF.
  - Fields stay unchanged and in_ready=0 throughout.
  - Raise out_ready; the next frame of 0x1234 with last yields out_sum=0x1234, out_count=1.
- Overflow with MAX_LEN=4: send 6 words 0x0001, 0x0002, 0x0004, 0x0008, 0x0010, 0x0020, the last with in_last.
  - Result: out_count=4, out_overflow=1, out_sum=0x003F, out_parity=0.
  - Overflow must be clear on the following frame.
- Reset mid-frame: accept 0x00FF and 0x0F00, then assert reset between clock edges.
  - Outputs must reach reset values immediately.
  - After release, frame 0x0003 with last yields out_sum=0x0003, out_count=1.
- Back-to-back frames: hold out_ready=1 continuously and stream 0x000A(last), 0x0005(last).
  - Two results, 0x000A then 0x0005, each with count 1.
  - One DONE cycle between frames.

Source files
------------

// File: rtl/xor_checksum_unit.sv
// Streaming XOR checksum engine: folds a frame of words into a running XOR
// and presents checksum, parity, word count and overflow on a held output
// handshake until the consumer takes it.

module xor_gate #(
   parameter int unsigned WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   // Bitwise XOR primitive.
   assign y = a ^ b;

endmodule

module xor_checksum_unit #(
   parameter int unsigned  WIDTH   = 16,
   parameter int unsigned  MAX_LEN = 256,
   localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_parity,
   output logic [LEN_W-1:0] out_count,
   output logic             out_overflow
);

   typedef enum logic {
      ACCUM = 1'b0,
      DONE  = 1'b1
   } state_t;

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   acc, acc_nxt;
   logic [WIDTH-1:0]   acc_fold;
   logic [LEN_W-1:0]   count, count_nxt;
   logic               ovf, ovf_nxt;
   logic               par, par_nxt;

   // Candidate accumulator value if the current input word is accepted.
   xor_gate #(.WIDTH(WIDTH)) u_fold (
      .a (acc),
      .b (in_data),
      .y (acc_fold)
   );

   // State and result registers; reset discards any frame in progress.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ACCUM;
         acc   <= '0;
         count <= '0;
         ovf   <= 1'b0;
         par   <= 1'b0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         count <= count_nxt;
         ovf   <= ovf_nxt;
         par   <= par_nxt;
      end
   end

   // Next-state: fold accepted words in ACCUM, hold in DONE until taken.
   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      count_nxt = count;
      ovf_nxt   = ovf;
      par_nxt   = par;
      case (state)
         ACCUM: begin
            if (in_valid) begin
               acc_nxt = acc_fold;
               par_nxt = ^acc_fold;
               // Counter saturates; words past the limit still fold into acc.
               if (count < LEN_W'(MAX_LEN)) begin
                  count_nxt = count + LEN_W'(1);
               end else begin
                  ovf_nxt = 1'b1;
               end
               if (in_last) begin
                  state_nxt = DONE;
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nxt = ACCUM;
               acc_nxt   = '0;
               count_nxt = '0;
               ovf_nxt   = 1'b0;
               par_nxt   = 1'b0;
            end
         end
         default: begin
            state_nxt = ACCUM;
         end
      endcase
   end

   // Handshake strobes decode straight from the state register.
   assign in_ready     = (state == ACCUM);
   assign out_valid    = (state == DONE);
   assign out_sum      = acc;
   assign out_parity   = par;
   assign out_count    = count;
   assign out_overflow = ovf;

endmodule
